writeback_unit: RTL and testbench

Single-write-port arbiter and pending-write scoreboard on the write side of the register file. Merges results from the single-cycle ALU and the variable-latency load/store unit (LSU) into one registered write (`WriteEnable`/`WriteReg`/`WriteData`). Buffers ALU results in a small FIFO while the LSU holds the port, and exposes per-register busy flags so issue logic can stall on RAW/WAW hazards.

---
 rtl/writeback_unit_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 57 +++++
 rtl/writeback_unit.sv | 139 +++++++++++++
 tb/tb_writeback_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// ============================================================================
// writeback_unit_pkg: register geometry, write-back source enum, FIFO entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package writeback_unit_pkg;

  localparam int REG_ADDR_SIZE = 5;
  localparam int REG_SIZE      = 32;
  localparam int NUM_REGS      = 1 << REG_ADDR_SIZE;

  typedef enum logic [2:0] {
    WB_NONE,
    WB_FORCE_FIFO,
    WB_LSU,
    WB_FIFO,
    WB_ALU
  } wb_src_t;

  typedef struct packed {
    logic [REG_ADDR_SIZE-1:0] rd;
    logic [REG_SIZE-1:0]      data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// wb_fifo: synchronous FIFO of pending ALU results {rd, data}
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // The extra top pointer bit tells full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [FIFO_DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
  end

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit: ALU/LSU write-port arbiter, starvation guard, pending scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [REG_ADDR_SIZE-1:0] alu_rd,
  input  logic [REG_SIZE-1:0]      alu_data,
  output logic                     alu_ready,
  input  logic                     lsu_valid,
  input  logic [REG_ADDR_SIZE-1:0] lsu_rd,
  input  logic [REG_SIZE-1:0]      lsu_data,
  output logic                     lsu_ready,
  input  logic                     issue_valid,
  input  logic [REG_ADDR_SIZE-1:0] issue_rd,
  input  logic [REG_ADDR_SIZE-1:0] query_rs1,
  input  logic [REG_ADDR_SIZE-1:0] query_rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     rd_busy,
  output logic                     WriteEnable,
  output logic [REG_ADDR_SIZE-1:0] WriteReg,
  output logic [REG_SIZE-1:0]      WriteData
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t                fifo_head, alu_entry, win;
  wb_src_t                  src;
  logic                     force_fifo;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     we_q, we_d;
  logic [REG_ADDR_SIZE-1:0] reg_q, reg_d;
  logic [REG_SIZE-1:0]      data_q, data_d;
  logic [NUM_REGS-1:0]      pending_q, pending_d;

  assign alu_entry = '{rd: alu_rd, data: alu_data};

  wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_entry_i(alu_entry),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign force_fifo = fifo_full && (starve_q == SW'(STARVE_LIMIT));
  assign alu_ready  = !fifo_full;
  assign lsu_ready  = !force_fifo;

  always_comb begin
    src = WB_NONE;
    win = fifo_head;
    if (force_fifo) begin
      src = WB_FORCE_FIFO;
    end else if (lsu_valid) begin
      src = WB_LSU;
      win = '{rd: lsu_rd, data: lsu_data};
    end else if (!fifo_empty) begin
      src = WB_FIFO;
    end else if (alu_valid) begin
      src = WB_ALU;
      win = alu_entry;
    end
  end

  assign fifo_pop  = (src == WB_FORCE_FIFO) || (src == WB_FIFO);
  assign fifo_push = alu_valid && !fifo_full && (src != WB_ALU);

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || !fifo_full) begin
      starve_d = '0;
    end else if ((src == WB_LSU) && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Consumed x0 results still move the address/data registers; only the enable drops.
  always_comb begin
    we_d   = 1'b0;
    reg_d  = reg_q;
    data_d = data_q;
    if (src != WB_NONE) begin
      we_d   = (win.rd != '0);
      reg_d  = win.rd;
      data_d = win.data;
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the register busy.
  always_comb begin
    pending_d = pending_q;
    if (we_q) pending_d[reg_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      we_q      <= 1'b0;
      reg_q     <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      we_q      <= we_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign rs1_busy    = pending_q[query_rs1];
  assign rs2_busy    = pending_q[query_rs2];
  assign rd_busy     = pending_q[issue_rd];
  assign WriteEnable = we_q;
  assign WriteReg    = reg_q;
  assign WriteData   = data_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// tb_writeback_unit: directed stimulus, queue-based reference model, per-cycle compare
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;
  import writeback_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0, query_rs1 = '0, query_rs2 = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, rd_busy, WriteEnable;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results waiting for the port kept as a plain queue.
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  bit   [31:0] m_pend = '0;

  initial forever begin
    ent_t win;
    bit   full, have, took_fifo, lsu_won, direct;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_starve = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_pend = '0;
    end else begin
      full = (mq.size() == DEPTH);
      have = 1'b0; took_fifo = 1'b0; lsu_won = 1'b0; direct = 1'b0;
      win = '0;
      if (full && m_starve == LIMIT) begin
        win = mq.pop_front(); have = 1'b1; took_fifo = 1'b1;
      end else if (lsu_valid) begin
        win = '{lsu_rd, lsu_data}; have = 1'b1; lsu_won = 1'b1;
      end else if (mq.size() > 0) begin
        win = mq.pop_front(); have = 1'b1; took_fifo = 1'b1;
      end else if (alu_valid) begin
        win = '{alu_rd, alu_data}; have = 1'b1; direct = 1'b1;
      end
      if (alu_valid && !full && !direct) mq.push_back('{alu_rd, alu_data});
      if (took_fifo || !full) m_starve = 0;
      else if (lsu_won && m_starve < LIMIT) m_starve = m_starve + 1;
      if (m_we) m_pend[m_reg] = 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (have) begin
        m_we = (win.rd != 0); m_reg = win.rd; m_data = win.data;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("cyc_we",   {31'b0, WriteEnable}, {31'b0, m_we});
    check("cyc_reg",  {27'b0, WriteReg}, {27'b0, m_reg});
    check("cyc_data", WriteData, m_data);
    check("cyc_alu_ready", {31'b0, alu_ready}, {31'b0, mq.size() < DEPTH});
    check("cyc_lsu_ready", {31'b0, lsu_ready},
          {31'b0, !(mq.size() == DEPTH && m_starve == LIMIT)});
    check("cyc_rs1_busy", {31'b0, rs1_busy}, {31'b0, (query_rs1 != 0) && m_pend[query_rs1]});
    check("cyc_rs2_busy", {31'b0, rs2_busy}, {31'b0, (query_rs2 != 0) && m_pend[query_rs2]});
    check("cyc_rd_busy",  {31'b0, rd_busy},  {31'b0, (issue_rd != 0) && m_pend[issue_rd]});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  bit la, aa;

  task automatic step(output bit lsu_acc, output bit alu_acc);
    @(negedge clk);
    lsu_acc = lsu_valid && lsu_ready;
    alu_acc = alu_valid && alu_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",   {31'b0, WriteEnable}, 32'd0);
    check("rst_reg",  {27'b0, WriteReg}, 32'd0);
    check("rst_data", WriteData, 32'd0);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Direct ALU write to x5 clears a pending bit one edge after WriteEnable.
    issue_valid = 1'b1; issue_rd = 5'd5; query_rs1 = 5'd5;
    step(la, aa);
    issue_valid = 1'b0; issue_rd = 5'd0;
    #1 check("t1_busy_set", {31'b0, rs1_busy}, 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step(la, aa);
    alu_valid = 1'b0;
    check("t1_we",   {31'b0, WriteEnable}, 32'd1);
    check("t1_reg",  {27'b0, WriteReg}, 32'd5);
    check("t1_data", WriteData, 32'h1234);
    check("t1_busy_still", {31'b0, rs1_busy}, 32'd1);
    step(la, aa);
    check("t1_busy_clr", {31'b0, rs1_busy}, 32'd0);
    check("t1_we_off", {31'b0, WriteEnable}, 32'd0);

    // ALU and LSU collide: LSU first, buffered ALU next.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hBBBB;
    #1 check("t2_alu_ready_pre", {31'b0, alu_ready}, 32'd1);
    step(la, aa);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("t2_lsu_acc", {31'b0, la}, 32'd1);
    check("t2_reg_lsu", {27'b0, WriteReg}, 32'd7);
    check("t2_data_lsu", WriteData, 32'hBBBB);
    check("t2_alu_ready", {31'b0, alu_ready}, 32'd1);
    step(la, aa);
    check("t2_we_alu", {31'b0, WriteEnable}, 32'd1);
    check("t2_reg_alu", {27'b0, WriteReg}, 32'd3);
    check("t2_data_alu", WriteData, 32'hAAAA);
    step(la, aa);

    // LSU streams while the FIFO fills; forced drain after LIMIT LSU wins.
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h1000;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
    step(la, aa);
    lsu_rd = 5'd11; lsu_data = 32'h1001; alu_rd = 5'd21; alu_data = 32'hA1;
    step(la, aa);
    alu_valid = 1'b0;
    check("t3_alu_ready_full", {31'b0, alu_ready}, 32'd0);
    for (int k = 0; k < LIMIT; k++) begin
      lsu_rd = 5'(12 + k); lsu_data = 32'h1002 + 32'(k);
      step(la, aa);
      check("t3_lsu_win", {31'b0, la}, 32'd1);
    end
    lsu_rd = 5'd16; lsu_data = 32'h1006;
    #1 check("t3_lsu_stall", {31'b0, lsu_ready}, 32'd0);
    step(la, aa);
    check("t3_lsu_not_acc", {31'b0, la}, 32'd0);
    check("t3_force_reg", {27'b0, WriteReg}, 32'd20);
    check("t3_force_data", WriteData, 32'hA0);
    check("t3_lsu_ready_back", {31'b0, lsu_ready}, 32'd1);
    step(la, aa);
    lsu_valid = 1'b0;
    check("t3_lsu16_reg", {27'b0, WriteReg}, 32'd16);
    step(la, aa);
    check("t3_drain_reg", {27'b0, WriteReg}, 32'd21);
    check("t3_drain_data", WriteData, 32'hA1);
    step(la, aa);

    // x0 result is consumed without a write.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF; query_rs1 = 5'd0;
    step(la, aa);
    alu_valid = 1'b0;
    check("t4_acc", {31'b0, aa}, 32'd1);
    check("t4_we", {31'b0, WriteEnable}, 32'd0);
    check("t4_x0_busy", {31'b0, rs1_busy}, 32'd0);
    step(la, aa);

    // Re-issue of x9 on the commit edge keeps it busy.
    issue_valid = 1'b1; issue_rd = 5'd9; query_rs1 = 5'd9;
    step(la, aa);
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    step(la, aa);
    alu_valid = 1'b0;
    check("t5_we", {31'b0, WriteEnable}, 32'd1);
    check("t5_reg", {27'b0, WriteReg}, 32'd9);
    issue_valid = 1'b1; issue_rd = 5'd9;
    step(la, aa);
    issue_valid = 1'b0; issue_rd = 5'd0;
    #1 check("t5_busy_kept", {31'b0, rs1_busy}, 32'd1);
    step(la, aa);

    // Reset mid-operation with two buffered results and x4 pending.
    issue_valid = 1'b1; issue_rd = 5'd4; query_rs1 = 5'd4; query_rs2 = 5'd4;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h5000;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h111;
    step(la, aa);
    issue_valid = 1'b0;
    lsu_rd = 5'd13; lsu_data = 32'h5001; alu_rd = 5'd2; alu_data = 32'h222;
    step(la, aa);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1 check("t6_pre_full", {31'b0, alu_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_we", {31'b0, WriteEnable}, 32'd0);
    check("t6_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("t6_rs1_busy", {31'b0, rs1_busy}, 32'd0);
    check("t6_rs2_busy", {31'b0, rs2_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      step(la, aa);
      check("t6_no_write", {31'b0, WriteEnable}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
